// File: rtl/word_serializer_pkg.sv
// -----------------------------------------------------------------------------
// word_serializer_pkg
// Shared definitions for the word-to-byte serializer slice.
//   - Datapath widths: input word, output byte, delivered-byte counter.
//   - FIFO entry layout: {data[15:0], half}.
//   - FSM state encoding of the output stage.
//   - pick_byte(): selects the upper or lower byte of a word.
// -----------------------------------------------------------------------------
package word_serializer_pkg;

    localparam int IN_W    = 16;
    localparam int OUT_W   = 8;
    localparam int CNT_W   = 16;
    localparam int ENTRY_W = IN_W + 1;  // word payload plus the half flag in bit 0

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] pick_byte(input logic [IN_W-1:0] word,
                                                   input logic             upper);
        return upper ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// -----------------------------------------------------------------------------
// word_serializer_if
// Bundles both streams of the serializer plus the delivered-byte counter.
//   Word side : in_valid, in_ready, in_data[15:0], in_half
//   Byte side : out_valid, out_ready, out_data[7:0], out_last
//   Status    : byte_count[15:0]
// Modports:
//   master - the environment: offers words and accepts bytes.
//   slave  - the serializer itself.
// -----------------------------------------------------------------------------
interface word_serializer_if;
    import word_serializer_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_half;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic [CNT_W-1:0] byte_count;

    modport master (
        output in_valid, in_data, in_half, out_ready,
        input  in_ready, out_valid, out_data, out_last, byte_count
    );

    modport slave (
        input  in_valid, in_data, in_half, out_ready,
        output in_ready, out_valid, out_data, out_last, byte_count
    );

endinterface

// File: rtl/word_serializer_ser_fifo.sv
// -----------------------------------------------------------------------------
// ser_fifo
// DEPTH-entry synchronous FIFO for serializer entries.
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (clears pointers and count)
//   i_push   in   write i_wdata (ignored when full)
//   i_pop    in   advance the read pointer (ignored when empty)
//   i_wdata  in   entry to store
//   o_rdata  out  entry at the head (valid whenever !o_empty)
//   o_full   out  count == DEPTH
//   o_empty  out  count == 0
// The head is read asynchronously so the output stage can load it in the
// same cycle it pops; the array is small enough to sit in LUT RAM.
// -----------------------------------------------------------------------------
module ser_fifo
    import word_serializer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = ENTRY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_BW = PTR_W + 1;

    logic [W-1:0]      r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_BW-1:0] r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CNT_BW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage is not reset: stale entries are never visible while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
// Buffers 16-bit words in a small FIFO and emits each one as one byte (half
// word) or two bytes on a registered 8-bit valid/ready stream.
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, synchronously released
//   bus    slave modport of word_serializer_if:
//            in_valid/in_ready/in_data/in_half   word input (in_ready = !full)
//            out_valid/out_ready/out_data/out_last byte output, registered
//            byte_count                           bytes delivered, wraps
// Parameters:
//   DEPTH      FIFO depth in words (power of two, 2..16)
//   MSB_FIRST  0: low byte leaves first, 1: high byte leaves first
// -----------------------------------------------------------------------------
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    word_serializer_if.slave  bus
);

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_xfer;
    logic [ENTRY_W-1:0] w_head;

    state_t             r_state;
    state_t             w_state_next;
    logic [OUT_W-1:0]   r_data;
    logic [OUT_W-1:0]   r_second;
    logic               r_half;
    logic               r_last;
    logic [CNT_W-1:0]   r_byte_count;
    logic [OUT_W-1:0]   w_data_next;
    logic [OUT_W-1:0]   w_second_next;
    logic               w_half_next;
    logic               w_last_next;

    // Ready depends only on the registered occupancy, never on out_ready.
    assign w_push = bus.in_valid && !w_full;
    assign w_xfer = (r_state != ST_IDLE) && bus.out_ready;

    ser_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({bus.in_data, bus.in_half}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and pop decision. Leaving a word's final byte pops the
    // next word in the same cycle so a back-to-back stream has no bubble.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (w_xfer) begin
                    if (!r_half) begin
                        w_state_next = ST_SECOND;
                    end else if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_FIRST;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_SECOND: begin
                if (w_xfer) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_FIRST;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output-stage next values. Both bytes are captured at pop time so the
    // FIFO slot is free immediately; r_second waits for the FIRST transfer.
    always_comb begin
        w_data_next   = r_data;
        w_second_next = r_second;
        w_half_next   = r_half;
        w_last_next   = r_last;
        if (w_pop) begin
            w_data_next   = pick_byte(w_head[IN_W:1], MSB_FIRST);
            w_second_next = pick_byte(w_head[IN_W:1], !MSB_FIRST);
            w_half_next   = w_head[0];
            w_last_next   = w_head[0];
        end else if ((r_state == ST_FIRST) && (w_state_next == ST_SECOND)) begin
            w_data_next = r_second;
            w_last_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_second     <= '0;
            r_half       <= 1'b0;
            r_last       <= 1'b0;
            r_byte_count <= '0;
        end else begin
            r_data   <= w_data_next;
            r_second <= w_second_next;
            r_half   <= w_half_next;
            r_last   <= w_last_next;
            if (w_xfer) begin
                r_byte_count <= r_byte_count + 1'b1;
            end
        end
    end

    assign bus.in_ready   = !w_full;
    assign bus.out_valid  = (r_state != ST_IDLE);
    assign bus.out_data   = r_data;
    assign bus.out_last   = r_last;
    assign bus.byte_count = r_byte_count;

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Upstream feeder for the byte-wide shift stage.
- Accepts 16-bit words over a valid/ready handshake and buffers them in a small FIFO.
- Emits each word as one or two bytes on an 8-bit valid/ready stream, which drives the shift stage's 8-bit input.
- Keeps a wrapping count of bytes delivered.

Parameters:
- DEPTH, 2: FIFO depth in words. Power of two, 2..16.
- MSB_FIRST, 0: 0 sends in_data[7:0] first; 1 sends in_data[15:8] first.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  word offered.
- in_ready  output  1  FIFO can accept; equals !full, driven from registered state only.
- in_data  input  16  word payload.
- in_half  input  1  only the first-sent byte of the word is meaningful.
- out_valid  output  1  out_data holds a byte.
- out_ready  input  1  downstream takes the byte.
- out_data  output  8  byte payload, registered.
- out_last  output  1  this byte is the final byte of its word.
- byte_count  output  16  bytes transferred, wraps modulo 2^16.

Behaviour:
- Reset (async assert, sync release): FIFO empty, FSM IDLE, out_valid=0, out_data=0, out_last=0, byte_count=0, in_ready=1. Reset mid-word discards buffered and in-flight data.
- Input accept: in_valid && in_ready sampled at a rising edge. The FIFO stores {in_data, in_half}.
- When full, in_ready=0 even if a pop occurs in the same cycle. There is no combinational ready path.
- Simultaneous push and pop when not full: both occur and the occupancy count is unchanged.
- FSM states and transitions:
  - IDLE (out_valid=0): if FIFO non-empty, pop the head, load the first byte, go to FIRST. If the popped word has in_half=1, set out_last=1.
  - FIRST (out_valid=1): hold the byte while out_ready=0.
    - On transfer with half=0: load the second byte, out_last=1, go to SECOND.
    - On transfer with half=1: same as the "next" rule below.
  - SECOND (out_valid=1, out_last=1): hold while out_ready=0. On transfer, apply the "next" rule.
  - "Next" rule: if FIFO non-empty, pop and load the first byte of the new word into FIRST with no bubble cycle. Otherwise go to IDLE with out_valid=0.
- Latency:
  - Word accepted at edge N into an empty block: out_valid=1 after edge N+1.
  - Sustained throughput: one byte per cycle. Input rate is limited to one word per two cycles for full words, one per cycle for half words.
- out_data, out_last and out_valid are stable while out_valid && !out_ready (AXI-style hold).
- byte_count increments by 1 on every out_valid && out_ready. 0xFFFF wraps to 0x0000.
- The FIFO uses log2(DEPTH)-bit read/write pointers that wrap naturally, plus a (log2(DEPTH)+1)-bit occupancy counter.
  - full = (count == DEPTH); empty = (count == 0).

Decomposition:
- Shared header/package:
  - FSM state encodings: IDLE=2'd0, FIRST=2'd1, SECOND=2'd2.
  - IN_W=16, OUT_W=8, CNT_W=16.
- One sub-module, ser_fifo: parameterised DEPTH x 17-bit synchronous FIFO with push/pop/full/empty, async active-low reset.
- The FSM, output register and byte counter live in word_serializer.

Test Plan:
1. Reset then single word: push 0xA1B2 (half=0, MSB_FIRST=0) with out_ready=1 -> bytes 0xB2 (last=0) then 0xA1 (last=1). out_valid rises one edge after accept. byte_count=2.
2. Half word: push 0x77C3, half=1 -> single byte 0xC3 with last=1. byte_count increments by 1. Return to IDLE.
3. Backpressure/full: out_ready=0, push 3 words with DEPTH=2 -> in_ready drops after the third accept (two in FIFO, one in output stage). out_data is held constant for 10 cycles. Release -> 6 bytes in order, no gaps.
4. Streaming: continuous valid words and out_ready=1 -> out_valid stays 1 every cycle with no bubbles. in_ready toggles to pace input at one word per 2 cycles.
5. MSB_FIRST=1: push 0x1234 -> 0x12 then 0x34.
6. Wrap and reset: preload byte_count to 0xFFFE via 2 remaining-count transfers (run 65534 bytes) -> 0xFFFF then 0x0000. Assert rst_n low mid-SECOND -> out_valid=0, FIFO empty, and in_ready=1 immediately (asynchronously).
